// File: rtl/res_station_age.sv
// Tomasulo reservation station with oldest-first issue.
//
// ENTRIES slots, each holding an opcode and two operands (Q = producer tag, V = value;
// Q == 0 means V is valid). Slots are addressed on the CDB by {RS_ID, slot}.
// An age matrix records allocation order so the oldest ready slot is always presented.
//
// Ports:
//   clk, nRST            clock (rising edge), asynchronous active-low reset
//   flush_i              synchronous clear of all slots, highest priority
//   in_valid_i/in_ready_o dispatch handshake; in_op_i, in_tag{1,2}_i, in_data{1,2}_i
//   alloc_tag_o          tag the next dispatched instruction receives
//   bc_valid_i/bc_tag_i/bc_data_i  CDB broadcast (wakeup, bypass and slot free)
//   iss_valid_o/iss_ready_i        issue handshake; iss_op_o, iss_data{1,2}_o, iss_tag_o
//   count_o              number of busy slots
module res_station_age #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned OPW     = 2,
  parameter int unsigned TAGW    = 4,
  parameter int unsigned RS_ID   = 1
) (
  input  logic                      clk,
  input  logic                      nRST,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [OPW-1:0]            in_op_i,
  input  logic [TAGW-1:0]           in_tag1_i,
  input  logic [DW-1:0]             in_data1_i,
  input  logic [TAGW-1:0]           in_tag2_i,
  input  logic [DW-1:0]             in_data2_i,
  output logic [TAGW-1:0]           alloc_tag_o,
  input  logic                      bc_valid_i,
  input  logic [TAGW-1:0]           bc_tag_i,
  input  logic [DW-1:0]             bc_data_i,
  output logic                      iss_valid_o,
  input  logic                      iss_ready_i,
  output logic [OPW-1:0]            iss_op_o,
  output logic [DW-1:0]             iss_data1_o,
  output logic [DW-1:0]             iss_data2_o,
  output logic [TAGW-1:0]           iss_tag_o,
  output logic [$clog2(ENTRIES):0]  count_o
);

  localparam int unsigned SW  = $clog2(ENTRIES);
  localparam int unsigned IDW = TAGW - SW;
  localparam logic [IDW-1:0] RsId = IDW'(RS_ID);

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] issued_q, issued_d;
  logic [OPW-1:0]     op_q [ENTRIES];
  logic [OPW-1:0]     op_d [ENTRIES];
  logic [TAGW-1:0]    q1_q [ENTRIES];
  logic [TAGW-1:0]    q1_d [ENTRIES];
  logic [TAGW-1:0]    q2_q [ENTRIES];
  logic [TAGW-1:0]    q2_d [ENTRIES];
  logic [DW-1:0]      v1_q [ENTRIES];
  logic [DW-1:0]      v1_d [ENTRIES];
  logic [DW-1:0]      v2_q [ENTRIES];
  logic [DW-1:0]      v2_d [ENTRIES];
  // older_q[i][j] = 1: slot i was allocated before slot j (only meaningful while both busy)
  logic [ENTRIES-1:0] older_q [ENTRIES];
  logic [ENTRIES-1:0] older_d [ENTRIES];

  logic [ENTRIES-1:0] ready, sel, alloc_oh;
  logic [SW-1:0]      free_idx;
  logic               accept, iss_fire, byp1, byp2, bc_wake;

  function automatic logic [TAGW-1:0] slot_tag(int i);
    return {RsId, SW'(i)};
  endfunction

  // Allocation uses registered busy only, so a slot freed this cycle is not reused yet.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = SW'(i);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      alloc_oh[i] = !busy_q[i] && (free_idx == SW'(i));
    end
  end

  assign in_ready_o  = ~&busy_q;
  assign accept      = in_valid_i && in_ready_o;
  assign alloc_tag_o = {RsId, free_idx};

  // Oldest ready slot: ready and no other ready slot is older.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy_q[i] && !issued_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
    for (int i = 0; i < ENTRIES; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < ENTRIES; j++) begin
        if (j != i && ready[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  // sel is one-hot or zero, so an OR-mux yields zeros when nothing is presented.
  always_comb begin
    iss_op_o    = '0;
    iss_data1_o = '0;
    iss_data2_o = '0;
    iss_tag_o   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel[i]) begin
        iss_op_o    = iss_op_o | op_q[i];
        iss_data1_o = iss_data1_o | v1_q[i];
        iss_data2_o = iss_data2_o | v2_q[i];
        iss_tag_o   = iss_tag_o | slot_tag(i);
      end
    end
  end

  assign iss_valid_o = |sel;
  assign iss_fire    = iss_valid_o && iss_ready_i;

  always_comb begin
    count_o = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      count_o = count_o + {{SW{1'b0}}, busy_q[i]};
    end
  end

  assign bc_wake = bc_valid_i && (bc_tag_i != '0);
  assign byp1    = bc_wake && (bc_tag_i == in_tag1_i);
  assign byp2    = bc_wake && (bc_tag_i == in_tag2_i);

  always_comb begin
    busy_d   = busy_q;
    issued_d = issued_q;
    op_d     = op_q;
    q1_d     = q1_q;
    q2_d     = q2_q;
    v1_d     = v1_q;
    v2_d     = v2_q;
    older_d  = older_q;
    if (flush_i) begin
      busy_d   = '0;
      issued_d = '0;
      for (int i = 0; i < ENTRIES; i++) older_d[i] = '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (bc_wake && busy_q[i]) begin
          if (q1_q[i] == bc_tag_i) begin
            q1_d[i] = '0;
            v1_d[i] = bc_data_i;
          end
          if (q2_q[i] == bc_tag_i) begin
            q2_d[i] = '0;
            v2_d[i] = bc_data_i;
          end
        end
        if (iss_fire && sel[i]) issued_d[i] = 1'b1;
        if (bc_valid_i && (bc_tag_i == slot_tag(i))) busy_d[i] = 1'b0;
      end
      // The allocated slot was not busy, so the wakeup/free above never touched it.
      for (int i = 0; i < ENTRIES; i++) begin
        if (accept && alloc_oh[i]) begin
          busy_d[i]   = 1'b1;
          issued_d[i] = 1'b0;
          op_d[i]     = in_op_i;
          q1_d[i]     = byp1 ? '0 : in_tag1_i;
          v1_d[i]     = byp1 ? bc_data_i : in_data1_i;
          q2_d[i]     = byp2 ? '0 : in_tag2_i;
          v2_d[i]     = byp2 ? bc_data_i : in_data2_i;
          older_d[i]  = '0;
          for (int j = 0; j < ENTRIES; j++) begin
            if (j != i) older_d[j][i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q   <= '0;
      issued_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        q1_q[i]    <= '0;
        q2_q[i]    <= '0;
        v1_q[i]    <= '0;
        v2_q[i]    <= '0;
        older_q[i] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      issued_q <= issued_d;
      op_q     <= op_d;
      q1_q     <= q1_d;
      q2_q     <= q2_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      older_q  <= older_d;
    end
  end

endmodule

// File: tb/tb_res_station_age.sv
module tb_res_station_age;
  localparam int unsigned ENT  = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned OPW  = 2;
  localparam int unsigned TAGW = 4;
  localparam int unsigned RSID = 1;

  logic            clk = 1'b0;
  logic            nRST = 1'b0;
  logic            flush, in_valid, in_ready, bc_valid, iss_valid, iss_ready;
  logic [OPW-1:0]  in_op, iss_op;
  logic [TAGW-1:0] in_tag1, in_tag2, alloc_tag, bc_tag, iss_tag;
  logic [DW-1:0]   in_data1, in_data2, bc_data, iss_data1, iss_data2;
  logic [2:0]      count;

  always #5 clk = ~clk;

  res_station_age #(
    .ENTRIES(ENT), .DW(DW), .OPW(OPW), .TAGW(TAGW), .RS_ID(RSID)
  ) dut (
    .clk        (clk),
    .nRST       (nRST),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_op_i    (in_op),
    .in_tag1_i  (in_tag1),
    .in_data1_i (in_data1),
    .in_tag2_i  (in_tag2),
    .in_data2_i (in_data2),
    .alloc_tag_o(alloc_tag),
    .bc_valid_i (bc_valid),
    .bc_tag_i   (bc_tag),
    .bc_data_i  (bc_data),
    .iss_valid_o(iss_valid),
    .iss_ready_i(iss_ready),
    .iss_op_o   (iss_op),
    .iss_data1_o(iss_data1),
    .iss_data2_o(iss_data2),
    .iss_tag_o  (iss_tag),
    .count_o    (count)
  );

  // Reference model: slots with an allocation sequence number; oldest = smallest seq.
  typedef struct {
    logic            busy;
    logic            issued;
    logic [OPW-1:0]  op;
    logic [TAGW-1:0] q1, q2;
    logic [DW-1:0]   v1, v2;
    int              seq;
  } slot_t;

  slot_t m[ENT];
  int    seq_ctr = 0;
  int    n_total = 0;
  int    n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_sel();
    int best = -1;
    for (int i = 0; i < ENT; i++) begin
      if (m[i].busy && !m[i].issued && m[i].q1 == 0 && m[i].q2 == 0)
        if (best < 0 || m[i].seq < m[best].seq) best = i;
    end
    return best;
  endfunction

  function automatic int m_free();
    for (int i = 0; i < ENT; i++) if (!m[i].busy) return i;
    return -1;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < ENT; i++) if (m[i].busy) c++;
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < ENT; i++) begin
      m[i].busy   = 1'b0;
      m[i].issued = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int s = m_sel();
    int f = m_free();
    check("in_ready", 64'(in_ready), 64'(f >= 0));
    check("count", 64'(count), 64'(m_count()));
    check("iss_valid", 64'(iss_valid), 64'(s >= 0));
    if (s >= 0) begin
      check("iss_op", 64'(iss_op), 64'(m[s].op));
      check("iss_data1", 64'(iss_data1), 64'(m[s].v1));
      check("iss_data2", 64'(iss_data2), 64'(m[s].v2));
      check("iss_tag", 64'(iss_tag), 64'(RSID * ENT + s));
    end else begin
      check("iss_idle", {iss_op, iss_tag, iss_data1 | iss_data2}, 64'd0);
    end
    if (f >= 0) check("alloc_tag", 64'(alloc_tag), 64'(RSID * ENT + f));
  endtask

  // Advance the model across one clock edge using the inputs held during that edge.
  task automatic m_update();
    int   s   = m_sel();
    int   f   = m_free();
    logic hs  = (s >= 0) && iss_ready;
    logic acc = in_valid && (f >= 0);
    if (flush) begin
      m_reset();
    end else begin
      if (bc_valid && bc_tag != 0) begin
        for (int i = 0; i < ENT; i++) begin
          if (m[i].busy && m[i].q1 == bc_tag) begin m[i].q1 = 0; m[i].v1 = bc_data; end
          if (m[i].busy && m[i].q2 == bc_tag) begin m[i].q2 = 0; m[i].v2 = bc_data; end
        end
      end
      if (hs) m[s].issued = 1'b1;
      if (bc_valid && int'(bc_tag) / ENT == RSID) m[int'(bc_tag) % ENT].busy = 1'b0;
      if (acc) begin
        m[f].busy   = 1'b1;
        m[f].issued = 1'b0;
        m[f].op     = in_op;
        if (bc_valid && in_tag1 != 0 && bc_tag == in_tag1) begin
          m[f].q1 = 0; m[f].v1 = bc_data;
        end else begin
          m[f].q1 = in_tag1; m[f].v1 = in_data1;
        end
        if (bc_valid && in_tag2 != 0 && bc_tag == in_tag2) begin
          m[f].q2 = 0; m[f].v2 = bc_data;
        end else begin
          m[f].q2 = in_tag2; m[f].v2 = in_data2;
        end
        m[f].seq = seq_ctr++;
      end
    end
  endtask

  task automatic step();
    check_outputs();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic set_idle();
    flush = 0; in_valid = 0; in_op = 0; in_tag1 = 0; in_tag2 = 0;
    in_data1 = 0; in_data2 = 0; bc_valid = 0; bc_tag = 0; bc_data = 0; iss_ready = 0;
  endtask

  task automatic disp(input int op, input int t1, input int d1, input int t2, input int d2);
    in_valid = 1; in_op = OPW'(op); in_tag1 = TAGW'(t1); in_data1 = DW'(d1);
    in_tag2 = TAGW'(t2); in_data2 = DW'(d2);
  endtask

  task automatic bcast(input int t, input int d);
    bc_valid = 1; bc_tag = TAGW'(t); bc_data = DW'(d);
  endtask

  function automatic logic [TAGW-1:0] pick_tag();
    int r = int'($urandom_range(0, 3));
    if (r < 2) return '0;
    if (r == 2) return TAGW'(RSID * ENT + $urandom_range(0, ENT - 1));
    return TAGW'($urandom_range(8, 15));
  endfunction

  initial begin
    set_idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    nRST = 1;
    step();

    // Ready dispatch presents next cycle.
    disp(2, 0, 5, 0, 7); step();
    set_idle();
    check("t2_valid", 64'(iss_valid), 64'd1);
    check("t2_data1", 64'(iss_data1), 64'd5);
    check("t2_data2", 64'(iss_data2), 64'd7);
    check("t2_tag", 64'(iss_tag), 64'd4);
    iss_ready = 1; step();
    set_idle(); bcast(4, 0); step();
    set_idle(); step();

    // Wakeup of a waiting slot and bypass into a dispatching one in the same cycle.
    disp(1, 9, 0, 0, 3); step();
    set_idle(); disp(3, 9, 0, 9, 0); bcast(9, 'hAB); step();
    set_idle();
    check("t3_first", 64'(iss_tag), 64'd4);
    check("t3_v1", 64'(iss_data1), 64'hAB);
    iss_ready = 1; step();
    check("t3_second", 64'(iss_tag), 64'd5);
    check("t3_v2", 64'(iss_data2), 64'hAB);
    step();
    set_idle(); bcast(4, 0); step();
    bcast(5, 0); step();
    set_idle();

    // Age ordering: slot3 ready first, then slot0; slots 1 and 2 woken together.
    disp(0, 8, 0, 0, 1); step();
    disp(1, 9, 0, 0, 2); step();
    disp(2, 9, 0, 0, 3); step();
    disp(3, 11, 0, 0, 4); step();
    disp(1, 0, 0, 0, 0); step();
    set_idle(); bcast(11, 'h33); step();
    check("t4_slot3", 64'(iss_tag), 64'd7);
    iss_ready = 1; bcast(8, 'h88); step();
    check("t4_slot0", 64'(iss_tag), 64'd4);
    set_idle(); iss_ready = 1; step();
    bcast(9, 'h99); step();
    set_idle(); iss_ready = 1;
    check("t4_slot1", 64'(iss_tag), 64'd5);
    step();
    check("t4_slot2", 64'(iss_tag), 64'd6);
    step();

    // Full station ignores dispatch; freeing slot 2 reopens it next cycle.
    set_idle();
    check("t5_full", 64'(in_ready), 64'd0);
    disp(2, 0, 1, 0, 1); step();
    disp(2, 0, 1, 0, 1); bcast(6, 0); step();
    set_idle();
    check("t5_ready", 64'(in_ready), 64'd1);
    check("t5_alloc", 64'(alloc_tag), 64'd6);
    check("t5_count", 64'(count), 64'd3);
    bcast(4, 0); step();
    bcast(5, 0); step();
    bcast(7, 0); step();
    set_idle();

    // Backpressure holds outputs; flush beats a concurrent dispatch.
    disp(1, 0, 11, 0, 22); step();
    set_idle();
    for (int k = 0; k < 3; k++) begin
      check("t6_hold_tag", 64'(iss_tag), 64'd4);
      check("t6_hold_d1", 64'(iss_data1), 64'd11);
      step();
    end
    flush = 1; disp(2, 0, 1, 0, 1); bcast(4, 0); iss_ready = 1; step();
    set_idle();
    check("t6_count", 64'(count), 64'd0);
    check("t6_valid", 64'(iss_valid), 64'd0);

    // Randomized traffic against the model, with an asynchronous reset mid-stream.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        nRST = 0;
        #1;
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        check("rst_mid_valid", 64'(iss_valid), 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        nRST = 1;
      end
      flush     = ($urandom_range(0, 63) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_op     = OPW'($urandom);
      in_tag1   = pick_tag();
      in_tag2   = pick_tag();
      in_data1  = $urandom;
      in_data2  = $urandom;
      bc_valid  = $urandom_range(0, 2) != 0;
      bc_tag    = TAGW'($urandom_range(0, 15));
      bc_data   = $urandom;
      iss_ready = $urandom_range(0, 3) != 0;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
